coin_acceptor: RTL

//   Front-end of the beverage vending path. Converts two raw, asynchronous,

---
 rtl/coin_acceptor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes and debounces the 50c / 1 EUR sensors into
// one-cycle coin codes, rejects ambiguous or disabled coins, and latches a stuck-sensor fault.
module coin_acceptor #(
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  STUCK_CYCLES    = 1000,
  localparam int CNT_W           = $clog2(STUCK_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s50_raw,
  input  logic       s100_raw,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       reject,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, QUAL, RELEASE, FAULT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic             s50_meta, s50_q, s100_meta, s100_q;
  logic             kind;        // 0 = 50 cent, 1 = 1 Euro
  logic [CNT_W-1:0] cnt;         // high run while qualifying, low run while releasing
  logic [CNT_W-1:0] stuck_cnt;
  logic             own, other, any_high;

  assign own      = kind ? s100_q : s50_q;
  assign other    = kind ? s50_q  : s100_q;
  assign any_high = s50_q | s100_q;

  // Synchronizers, coin FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s50_meta  <= 1'b0;
      s50_q     <= 1'b0;
      s100_meta <= 1'b0;
      s100_q    <= 1'b0;
      state     <= IDLE;
      kind      <= 1'b0;
      cnt       <= '0;
      stuck_cnt <= '0;
      coin      <= 2'b00;
      reject    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      s50_meta  <= s50_raw;
      s50_q     <= s50_meta;
      s100_meta <= s100_raw;
      s100_q    <= s100_meta;
      coin      <= 2'b00;
      reject    <= 1'b0;
      case (state)
        IDLE: begin
          if ((s50_q ^ s100_q) && accept_en) begin
            kind <= s100_q;
            if (DEBOUNCE_CYCLES == 1) begin
              coin      <= s100_q ? 2'b10 : 2'b01;
              cnt       <= '0;
              stuck_cnt <= '0;
              state     <= RELEASE;
            end else begin
              cnt   <= CNT_ONE;
              state <= QUAL;
            end
          end else if (any_high) begin
            reject    <= 1'b1;
            cnt       <= '0;
            stuck_cnt <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= '0;
          end
        end
        QUAL: begin
          if (!own) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (other || !accept_en) begin
            reject    <= 1'b1;
            cnt       <= '0;
            stuck_cnt <= '0;
            state     <= RELEASE;
          end else if (cnt == DEB_LAST) begin
            coin      <= kind ? 2'b10 : 2'b01;
            cnt       <= '0;
            stuck_cnt <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RELEASE: begin
          // Stuck time accumulates over the whole release, not just one high run.
          if (any_high) begin
            cnt <= '0;
            if (stuck_cnt == STUCK_LAST) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              stuck_cnt <= stuck_cnt + CNT_ONE;
            end
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
